display_scan_driver: RTL and testbench

Time-multiplexed scan driver for a 4-digit common-anode seven-segment display. Holds a 16-bit hex value (4 nibbles), steps through the digits at a prescaled refresh rate, and presents one nibble at a time to the downstream seven-segment decoder together with the matching active-low digit enable. New values are accepted through a load/ready handshake and take effect only at a frame boundary, so a frame never mixes old and new digits. Optional leading-zero blanking is included.

---
 rtl/display_scan_if.sv | 37 +++
 rtl/display_scan_driver.sv | 86 ++++++++
 tb/tb_display_scan_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Handshake and display bus between a value source and the scan driver.
// The source side loads hex values; the driver side presents the
// currently scanned digit to a seven-segment decoder.
interface display_scan_if;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        ready;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        blank;
    logic        frame_tick;

    // Source of display values and consumer of the scan outputs.
    modport master (
        output load,
        output value,
        output blank_lz,
        input  ready,
        input  nibble,
        input  an,
        input  blank,
        input  frame_tick
    );

    // The scan driver itself.
    modport slave (
        input  load,
        input  value,
        input  blank_lz,
        output ready,
        output nibble,
        output an,
        output blank,
        output frame_tick
    );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode seven-segment
// display. A 16-bit value is shown one nibble at a time, each digit held for
// PRESCALE cycles. New values are double-buffered and only committed on the
// frame wrap, so one frame never mixes digits of two different values.
module display_scan_driver #(
    parameter int PRESCALE = 50000
) (
    input  logic           clk,
    input  logic           reset,
    display_scan_if.slave  bus
);

    localparam int              CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      disp;
    logic [15:0]      pend;
    logic             pending;
    logic             frame_tick_q;

    logic             step;
    logic             wrap;
    logic             accept;
    logic             lead_zero;

    // Digit step at the end of each hold period; the wrap is the step out of
    // digit 3, which is also the only point where a new value may commit.
    assign step   = (cnt == CNT_LAST);
    assign wrap   = step && (idx == 2'd3);
    assign accept = bus.load && !pending;

    // Prescaler, digit index, double-buffered value and frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= 2'd0;
            disp         <= 16'h0000;
            pend         <= 16'h0000;
            pending      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values; blocking would let later lines see updates.
            cnt          <= step ? '0 : cnt + 1'b1;
            frame_tick_q <= wrap;
            if (step) begin
                idx <= idx + 2'd1;
            end
            // Commit and accept are mutually exclusive: accept needs the
            // pending flag clear, commit needs it set. A load accepted on the
            // wrap edge therefore waits a full frame for the next wrap.
            if (wrap && pending) begin
                disp    <= pend;
                pending <= 1'b0;
            end
            if (accept) begin
                pend    <= bus.value;
                pending <= 1'b1;
            end
        end
    end

    // Leading-zero detect: the current digit and every more significant one
    // are zero. Digit 0 is never considered a leading zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves lead_zero
        // unassigned, which would otherwise infer a latch.
        lead_zero = 1'b0;
        case (idx)
            2'd1:    lead_zero = (disp[15:4]  == 12'h000);
            2'd2:    lead_zero = (disp[15:8]  == 8'h00);
            2'd3:    lead_zero = (disp[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    end

    // Moore outputs decoded from registers; blank follows blank_lz directly.
    assign bus.an         = ~(4'b0001 << idx);
    assign bus.nibble     = disp[4*idx +: 4];
    assign bus.blank      = bus.blank_lz && lead_zero;
    assign bus.ready      = ~pending;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver. The driver issues one stimulus
// cycle at a time, advances a cycle-count based reference model and queues
// the expected outputs; the monitor pops and compares after every edge.
module tb_display_scan_driver;

    localparam int P     = 4;
    localparam int FRAME = 4 * P;

    typedef struct {
        logic       ready;
        logic [3:0] an;
        logic [3:0] nibble;
        logic       blank;
        logic       frame_tick;
    } exp_t;

    logic clk;
    logic reset;
    display_scan_if bus ();

    display_scan_driver #(.PRESCALE(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q[$];

    // Reference model state: edges since reset, shown value, pending values.
    int          t;
    logic [15:0] shown;
    logic [15:0] pend_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one clock edge of the specification's rules and queue the
    // outputs visible after that edge.
    task automatic model_step(input logic rst, input logic ld, input logic [15:0] val,
                              input logic blz);
        exp_t        e;
        int          digit;
        logic        was_ready;
        logic [15:0] upper;
        logic [3:0]  one;
        if (rst) begin
            t     = 0;
            shown = 16'h0000;
            pend_q.delete();
        end else begin
            was_ready = (pend_q.size() == 0);
            if ((t % FRAME) == FRAME - 1 && pend_q.size() > 0)
                shown = pend_q.pop_front();
            if (ld && was_ready)
                pend_q.push_back(val);
            t++;
        end
        digit        = (t % FRAME) / P;
        upper        = shown >> (4 * digit);
        one          = 4'b0001;
        e.an         = ~(one << digit);
        e.nibble     = upper[3:0];
        e.blank      = blz && (digit != 0) && (upper == 16'h0000);
        e.ready      = (pend_q.size() == 0);
        e.frame_tick = (t > 0) && ((t % FRAME) == 0);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [15:0] val,
                         input logic blz);
        @(negedge clk);
        reset        = rst;
        bus.load     = ld;
        bus.value    = val;
        bus.blank_lz = blz;
        model_step(rst, ld, val, blz);
    endtask

    task automatic idle(input int n, input logic blz);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, blz);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready",      16'(bus.ready),      16'(e.ready));
                check("an",         16'(bus.an),         16'(e.an));
                check("nibble",     16'(bus.nibble),     16'(e.nibble));
                check("blank",      16'(bus.blank),      16'(e.blank));
                check("frame_tick", 16'(bus.frame_tick), 16'(e.frame_tick));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        logic [31:0] r;
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.blank_lz = 1'b0;
        t            = 0;
        shown        = 16'h0000;

        // Reset for two cycles, then free-run past the first wrap.
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        idle(FRAME + 3, 1'b0);

        // Scan sequence of a committed value.
        drive(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Leading-zero blanking, enabled then disabled.
        drive(1'b0, 1'b1, 16'h0050, 1'b1);
        idle(2 * FRAME, 1'b1);
        idle(FRAME, 1'b0);
        drive(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(2 * FRAME, 1'b1);
        idle(FRAME, 1'b0);

        // Second load while busy is dropped.
        drive(1'b0, 1'b1, 16'hAAAA, 1'b0);
        drive(1'b0, 1'b1, 16'hBBBB, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Load coinciding with the wrap edge commits one frame later.
        while ((t % FRAME) != FRAME - 1) idle(1, 1'b0);
        drive(1'b0, 1'b1, 16'hC0DE, 1'b0);
        idle(2 * FRAME + 2, 1'b0);

        // Mid-frame reset with a value pending on digit 2.
        drive(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(FRAME + 1, 1'b0);
        while ((t % FRAME) != 0) idle(1, 1'b0);
        drive(1'b0, 1'b1, 16'h5678, 1'b0);
        while ((t % FRAME) != 2 * P) idle(1, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        idle(2 * FRAME, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 5) == 0),
                  16'(r >> (4 * $urandom_range(0, 4))),
                  ($urandom_range(0, 3) != 0));
        end

        idle(1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
